// File: rtl/ext_sensor_edge_capture_pkg.sv
// Shared constants for the external sensor edge-capture port.
package ext_sensor_edge_capture_pkg;
  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_W        = 8;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd4;
  localparam logic [2:0] ADDR_BOTH     = 3'd5;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd6;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // One decoded bus access for the current cycle.
  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/ext_sensor_db_chan.sv
// One input channel: synchroniser, debounce counter and filtered level.
// Events are combinational and flag the clock edge on which filt flips.
module ext_sensor_db_chan
  import ext_sensor_edge_capture_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_W        = DEF_DB_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            din,
  input  logic [DB_W-1:0] debounce,
  output logic            sync,
  output logic            filt,
  output logic            rise_evt,
  output logic            fall_evt
);
  logic [SYNC_STAGES-1:0] sff;
  logic [DB_W-1:0]        cnt;
  logic                   upd;

  assign sync = sff[SYNC_STAGES-1];
  // >= rather than == so a lowered DEBOUNCE mid-count still terminates.
  assign upd      = (sync != filt) && (cnt >= debounce);
  assign rise_evt = upd & sync;
  assign fall_evt = upd & ~sync;

  // Metastability chain for the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sff <= '0;
    else          sff <= {sff[SYNC_STAGES-2:0], din};
  end

  // Count consecutive disagreement cycles; accept the new level when long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (upd) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ext_sensor_edge_capture.sv
// Avalon-MM slave: multi-channel debounced input port with edge-capture irq.
module ext_sensor_edge_capture
  import ext_sensor_edge_capture_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_W        = DEF_DB_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  bus_req_t         req;
  logic [WIDTH-1:0] sync, filt, rise, fall, set_vec, clr_vec;
  logic [WIDTH-1:0] irq_mask, capture, edge_sel, both_edges;
  logic [DB_W-1:0]  debounce;
  logic [31:0]      rmux;

  assign req.we    = chipselect & ~write_n;
  assign req.addr  = address;
  assign req.wdata = writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    ext_sensor_db_chan #(.SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (in_port[i]),
      .debounce (debounce),
      .sync     (sync[i]),
      .filt     (filt[i]),
      .rise_evt (rise[i]),
      .fall_evt (fall[i])
    );
    assign set_vec[i] = both_edges[i] ? (rise[i] | fall[i])
                      : (edge_sel[i] == EDGE_FALL) ? fall[i] : rise[i];
  end

  assign clr_vec = (req.we && req.addr == ADDR_CAPTURE) ? req.wdata[WIDTH-1:0] : '0;

  // Control registers and capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask   <= '0;
      capture    <= '0;
      edge_sel   <= '0;
      both_edges <= '0;
      debounce   <= '0;
    end else begin
      capture <= (capture & ~clr_vec) | set_vec;
      if (req.we) begin
        case (req.addr)
          ADDR_IRQ_MASK: irq_mask   <= req.wdata[WIDTH-1:0];
          ADDR_EDGE_SEL: edge_sel   <= req.wdata[WIDTH-1:0];
          ADDR_BOTH:     both_edges <= req.wdata[WIDTH-1:0];
          ADDR_DEBOUNCE: debounce   <= req.wdata[DB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux; unused upper bits and the reserved slot read zero.
  always_comb begin
    rmux = '0;
    case (req.addr)
      ADDR_DATA:     rmux[WIDTH-1:0] = filt;
      ADDR_RAW:      rmux[WIDTH-1:0] = sync;
      ADDR_IRQ_MASK: rmux[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE:  rmux[WIDTH-1:0] = capture;
      ADDR_EDGE_SEL: rmux[WIDTH-1:0] = edge_sel;
      ADDR_BOTH:     rmux[WIDTH-1:0] = both_edges;
      ADDR_DEBOUNCE: rmux[DB_W-1:0]  = debounce;
      default: ;
    endcase
  end

  // Registered read data: one cycle latency, no wait states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rmux;
  end

  assign irq = |(capture & irq_mask);
endmodule

// File: tb/tb_ext_sensor_edge_capture.sv
// Directed + randomized bench with a window-based behavioural reference model.
module tb_ext_sensor_edge_capture;
  localparam int W  = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  ext_sensor_edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .DB_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ih = in_port sample history (0 = newest), sh = history of
  // synchronised values seen by the filter. filt flips when the last DEBOUNCE+1
  // synchronised samples all disagree with it.
  logic [W-1:0] ih [0:15];
  logic [W-1:0] sh [0:15];
  logic [W-1:0] fm, cm, mm, em, bm;
  int           dbm;
  logic [31:0]  exp_rd;
  logic         exp_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 16; j++) begin ih[j] = '0; sh[j] = '0; end
    fm = '0; cm = '0; mm = '0; em = '0; bm = '0; dbm = 0;
  endtask

  // Advance one clock, update the model with what the DUT saw, then check.
  task automatic step();
    logic [W-1:0] cur, setm, clr;
    logic         wr_now, all;
    logic [2:0]   a;
    logic [31:0]  wd;
    exp_rd = '0;
    case (address)
      3'd0: exp_rd[W-1:0] = fm;
      3'd1: exp_rd[W-1:0] = ih[SS-1];
      3'd2: exp_rd[W-1:0] = mm;
      3'd3: exp_rd[W-1:0] = cm;
      3'd4: exp_rd[W-1:0] = em;
      3'd5: exp_rd[W-1:0] = bm;
      3'd6: exp_rd[7:0]   = dbm[7:0];
      default: ;
    endcase
    cur = in_port; wr_now = chipselect & ~write_n; a = address; wd = writedata;
    @(posedge clk);
    for (int j = 15; j > 0; j--) begin ih[j] = ih[j-1]; sh[j] = sh[j-1]; end
    ih[0] = cur;
    sh[0] = ih[SS];
    setm = '0;
    for (int i = 0; i < W; i++) begin
      all = 1'b1;
      for (int j = 0; j <= dbm && j < 16; j++) if (sh[j][i] == fm[i]) all = 1'b0;
      if (all) begin
        fm[i]   = ~fm[i];
        setm[i] = bm[i] | (em[i] ? ~fm[i] : fm[i]);
      end
    end
    clr = (wr_now && a == 3'd3) ? wd[W-1:0] : '0;
    cm  = (cm & ~clr) | setm;
    if (wr_now) begin
      case (a)
        3'd2: mm  = wd[W-1:0];
        3'd4: em  = wd[W-1:0];
        3'd5: bm  = wd[W-1:0];
        3'd6: dbm = int'(wd[7:0]);
        default: ;
      endcase
    end
    exp_irq = |(cm & mm);
    #1;
    chk("rdata", readdata, exp_rd);
    chk("irq", {31'b0, irq}, {31'b0, exp_irq});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    step();
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    model_reset();
    // 1: reset state and all-zero register reads
    #3;
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk("reset_read", readdata, 32'h0);
    end

    // 2: DEBOUNCE=0, capture appears three edges after the change
    wr(3'd6, 32'h0); wr(3'd2, 32'h1);
    in_port[0] = 1'b1;
    steps(2);
    chk("lat_pre_irq", {31'b0, irq}, 32'h0);
    step();
    chk("lat_irq", {31'b0, irq}, 32'h1);
    rd(3'd3);
    chk("cap_read", readdata, 32'h1);
    wr(3'd3, 32'h1);
    chk("clr_irq", {31'b0, irq}, 32'h0);
    rd(3'd3);
    chk("cap_cleared", readdata, 32'h0);

    // 3: DEBOUNCE=3, short pulse rejected, held level accepted after 6 edges
    wr(3'd6, 32'h3);
    in_port[1] = 1'b1; steps(3);
    in_port[1] = 1'b0; steps(10);
    rd(3'd0);
    chk("pulse_data", readdata, 32'h1);
    rd(3'd3);
    chk("pulse_cap", readdata, 32'h0);
    address = 3'd0;
    in_port[1] = 1'b1;
    steps(6);
    chk("hold_pre", {31'b0, readdata[1]}, 32'h0);
    step();
    chk("hold_data", {31'b0, readdata[1]}, 32'h1);
    in_port[1] = 1'b0; steps(12);
    wr(3'd3, 32'hF);

    // 4: bit2 falling only, bit3 both edges
    wr(3'd6, 32'h0); wr(3'd4, 32'h4); wr(3'd5, 32'h8); wr(3'd3, 32'hF);
    in_port[3:2] = 2'b11; steps(6);
    rd(3'd3);
    chk("mode_rise", readdata, 32'h8);
    in_port[3:2] = 2'b00; steps(6);
    rd(3'd3);
    chk("mode_fall", readdata, 32'hC);

    // 5: W1C behaviour and set-wins on a same-cycle clear
    wr(3'd3, 32'hF);
    in_port = 4'b1010; steps(6);
    rd(3'd3);
    chk("cap_1010", readdata, 32'hA);
    wr(3'd3, 32'h2);
    rd(3'd3);
    chk("w1c_partial", readdata, 32'h8);
    in_port[3] = 1'b0;
    steps(2);
    wr(3'd3, 32'h8);
    rd(3'd3);
    chk("set_wins", readdata, 32'h8);

    // 6: reset mid-debounce clears everything, no spurious capture after
    wr(3'd2, 32'hF); wr(3'd6, 32'h5);
    in_port = 4'b0000; steps(12);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    address = 3'd3;
    in_port[0] = 1'b1; steps(4);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rdata", readdata, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    model_reset();
    in_port = '0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    address = 3'd3;
    steps(20);
    chk("post_rst_cap", readdata, 32'h0);
    rd(3'd6);
    chk("post_rst_db", readdata, 32'h0);

    // 7: randomized traffic against the model, DEBOUNCE fixed per round
    for (int r = 0; r < 3; r++) begin
      steps(12);
      wr(3'd2, $urandom); wr(3'd4, $urandom); wr(3'd5, $urandom);
      wr(3'd6, 32'($urandom_range(0, 3)));
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
        if ($urandom_range(0, 9) == 0) begin
          chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
          address = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd7;
        end else begin
          chipselect = 1'b0; write_n = 1'b1;
          address = 3'($urandom_range(0, 7));
        end
        step();
      end
      chipselect = 1'b0; write_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
